// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline hazard unit: forwarding, load-use stall, multi-cycle hold, branch flush
module hazard_sequencer #(
  parameter int MULT_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic [4:0] IDEX_Rs,
  input  logic [4:0] IDEX_Rt,
  input  logic       IDEX_MemRead,
  input  logic       IDEX_MultStart,
  input  logic       EXMEM_RegWrite,
  input  logic       MEMWB_RegWrite,
  input  logic [4:0] EXMEM_Rd,
  input  logic [4:0] MEMWB_Rd,
  input  logic       BranchTaken,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       Bubble,
  output logic       ExHold,
  output logic       FlushIFID,
  output logic       MultBusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(MULT_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic w_exmem_a;
  logic w_exmem_b;
  logic w_memwb_a;
  logic w_memwb_b;
  logic w_load_use;

  assign w_exmem_a  = EXMEM_RegWrite && (EXMEM_Rd != 5'd0) && (EXMEM_Rd == IDEX_Rs);
  assign w_exmem_b  = EXMEM_RegWrite && (EXMEM_Rd != 5'd0) && (EXMEM_Rd == IDEX_Rt);
  assign w_memwb_a  = MEMWB_RegWrite && (MEMWB_Rd != 5'd0) && (MEMWB_Rd == IDEX_Rs);
  assign w_memwb_b  = MEMWB_RegWrite && (MEMWB_Rd != 5'd0) && (MEMWB_Rd == IDEX_Rt);
  assign w_load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                      ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

  // Operand forwarding: newest producer (EX/MEM) wins; forced to register file during reset
  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (!Rst) begin
      if (w_exmem_a)      ForwardA = 2'b10;
      else if (w_memwb_a) ForwardA = 2'b01;
      if (w_exmem_b)      ForwardB = 2'b10;
      else if (w_memwb_b) ForwardB = 2'b01;
    end
  end

  // State and multi-cycle counter registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and control outputs; in IDLE branch beats multi-cycle start beats load-use
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    Bubble      = 1'b0;
    ExHold      = 1'b0;
    FlushIFID   = 1'b0;
    MultBusy    = 1'b0;
    if (!Rst) begin
      case (r_state)
        IDLE: begin
          if (BranchTaken) begin
            FlushIFID   = 1'b1;
            Bubble      = 1'b1;
            w_state_nxt = FLUSH;
          end else if (IDEX_MultStart) begin
            ExHold      = 1'b1;
            MultBusy    = 1'b1;
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            w_cnt_nxt   = LP_CNT_INIT;
            w_state_nxt = BUSY;
          end else if (w_load_use) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            Bubble    = 1'b1;
          end
        end
        BUSY: begin
          ExHold    = 1'b1;
          MultBusy  = 1'b1;
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          // Counter saturates at zero; reaching 1 (or an unexpected 0) ends the hold
          if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) w_state_nxt = IDLE;
        end
        FLUSH: begin
          FlushIFID   = 1'b1;
          Bubble      = 1'b1;
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rs, IDEX_Rt;
  logic       IDEX_MemRead, IDEX_MultStart;
  logic       EXMEM_RegWrite, MEMWB_RegWrite;
  logic [4:0] EXMEM_Rd, MEMWB_Rd;
  logic       BranchTaken;
  logic [1:0] ForwardA, ForwardB;
  logic       PCWrite, IFIDWrite, Bubble, ExHold, FlushIFID, MultBusy;

  int checks = 0;
  int errors = 0;

  hazard_sequencer #(.MULT_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_MultStart(IDEX_MultStart),
    .EXMEM_RegWrite(EXMEM_RegWrite), .MEMWB_RegWrite(MEMWB_RegWrite),
    .EXMEM_Rd(EXMEM_Rd), .MEMWB_Rd(MEMWB_Rd),
    .BranchTaken(BranchTaken),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .Bubble(Bubble),
    .ExHold(ExHold), .FlushIFID(FlushIFID), .MultBusy(MultBusy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {PCWrite, IFIDWrite, Bubble, ExHold, FlushIFID, MultBusy}
  task automatic check_ctl(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {PCWrite, IFIDWrite, Bubble, ExHold, FlushIFID, MultBusy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%06b expected=%06b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    IFID_Rs = 0; IFID_Rt = 0; IDEX_Rs = 0; IDEX_Rt = 0;
    IDEX_MemRead = 0; IDEX_MultStart = 0;
    EXMEM_RegWrite = 0; MEMWB_RegWrite = 0; EXMEM_Rd = 0; MEMWB_Rd = 0;
    BranchTaken = 0;
  endtask

  // Inputs change at negedge, outputs are sampled 1ns later, well before the next posedge
  task automatic next_cycle();
    @(negedge Clk);
    #1;
  endtask

  localparam logic [5:0] C_IDLE  = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b001000;
  localparam logic [5:0] C_MULT  = 6'b000101;
  localparam logic [5:0] C_FLUSH = 6'b111010;

  initial begin
    clear_inputs();
    Rst = 1'b1;
    // Reset with a forwarding hazard and branch present: everything must stay quiet
    @(negedge Clk);
    EXMEM_RegWrite = 1; EXMEM_Rd = 5'd5; IDEX_Rs = 5'd5; IDEX_Rt = 5'd5; BranchTaken = 1;
    #1;
    check("rst_fwda", {2'b0, ForwardA}, 4'h0);
    check("rst_fwdb", {2'b0, ForwardB}, 4'h0);
    check_ctl("rst_ctl", C_IDLE);
    next_cycle();
    check("rst_cnt", dut.r_cnt, 4'd0);

    // Forwarding: EX/MEM beats MEM/WB
    Rst = 1'b0;
    clear_inputs();
    EXMEM_RegWrite = 1; EXMEM_Rd = 5'd5; MEMWB_RegWrite = 1; MEMWB_Rd = 5'd5;
    IDEX_Rs = 5'd5; IDEX_Rt = 5'd0;
    #1;
    check("fwd_exmem_a", {2'b0, ForwardA}, 4'h2);
    check("fwd_exmem_b", {2'b0, ForwardB}, 4'h0);
    check_ctl("fwd_ctl_idle", C_IDLE);
    EXMEM_Rd = 5'd0;
    #1;
    check("fwd_memwb_a", {2'b0, ForwardA}, 4'h1);
    // B operand: MEM/WB only matches Rt, EX/MEM write disabled
    EXMEM_RegWrite = 0; EXMEM_Rd = 5'd9; IDEX_Rt = 5'd9; MEMWB_Rd = 5'd9; IDEX_Rs = 5'd3;
    #1;
    check("fwd_memwb_b", {2'b0, ForwardB}, 4'h1);
    check("fwd_none_a", {2'b0, ForwardA}, 4'h0);

    // Load-use stall for exactly one cycle
    next_cycle();
    clear_inputs();
    IDEX_MemRead = 1; IDEX_Rt = 5'd8; IFID_Rt = 5'd8;
    #1;
    check_ctl("lu_stall", C_STALL);
    next_cycle();
    clear_inputs();
    #1;
    check_ctl("lu_after", C_IDLE);
    IDEX_MemRead = 1; IDEX_Rt = 5'd0; IFID_Rt = 5'd0; IFID_Rs = 5'd0;
    #1;
    check_ctl("lu_r0_nostall", C_IDLE);

    // Multi-cycle op: four held cycles, branch in cycle 2 ignored
    next_cycle();
    clear_inputs();
    IDEX_MultStart = 1; IDEX_MemRead = 1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    #1;
    check_ctl("mult_c1", C_MULT);
    next_cycle();
    clear_inputs();
    BranchTaken = 1;
    #1;
    check_ctl("mult_c2_branch_ignored", C_MULT);
    check("mult_c2_cnt", dut.r_cnt, 4'd3);
    next_cycle();
    clear_inputs();
    check_ctl("mult_c3", C_MULT);
    next_cycle();
    check_ctl("mult_c4", C_MULT);
    check("mult_c4_cnt", dut.r_cnt, 4'd1);
    next_cycle();
    check_ctl("mult_done", C_IDLE);
    check("mult_done_cnt", dut.r_cnt, 4'd0);

    // Branch beats a simultaneous load-use hazard; flush lasts two slots
    next_cycle();
    clear_inputs();
    BranchTaken = 1; IDEX_MemRead = 1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    #1;
    check_ctl("br_slot1", C_FLUSH);
    next_cycle();
    BranchTaken = 0; IDEX_MultStart = 1;
    #1;
    check_ctl("br_slot2", C_FLUSH);
    next_cycle();
    clear_inputs();
    #1;
    check_ctl("br_done", C_IDLE);

    // Reset during BUSY at Cnt==2
    next_cycle();
    IDEX_MultStart = 1;
    #1;
    check_ctl("rmid_start", C_MULT);
    next_cycle();
    clear_inputs();
    next_cycle();
    check("rmid_cnt_before", dut.r_cnt, 4'd2);
    Rst = 1'b1;
    #1;
    check_ctl("rmid_during_rst", C_IDLE);
    next_cycle();
    Rst = 1'b0;
    #1;
    check_ctl("rmid_after", C_IDLE);
    check("rmid_cnt_after", dut.r_cnt, 4'd0);
    check("rmid_state", {2'b0, dut.r_state}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter: MULT_CYCLES, default 4, is the EX-stage occupancy of a multi-cycle op, legal range 2..15.
REQ-002 Clk  in  1  sole clock; all state SHALL update on posedge Clk.
REQ-003 Rst  in  1  synchronous, active-high reset.
REQ-004 IFID_Rs, IFID_Rt  in  5 each  source registers of the instruction in decode.
REQ-005 IDEX_Rs, IDEX_Rt  in  5 each  source registers of the instruction in EX.
REQ-006 IDEX_MemRead  in  1  EX instruction is a load.
REQ-007 IDEX_MultStart  in  1  EX instruction is a multi-cycle op, valid in the first EX cycle.
REQ-008 EXMEM_RegWrite, MEMWB_RegWrite  in  1 each  write enables of the later stages.
REQ-009 EXMEM_Rd, MEMWB_Rd  in  5 each  destination registers of the later stages.
REQ-010 BranchTaken  in  1  branch resolved taken in EX.
REQ-011 ForwardA, ForwardB  out  2 each  EX operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
REQ-012 PCWrite, IFIDWrite  out  1 each  PC and IF/ID register update enables.
REQ-013 Bubble  out  1  zero the EX/MEM/WB control fields entering ID/EX.
REQ-014 ExHold  out  1  hold the ID/EX register and EX outputs.
REQ-015 FlushIFID  out  1  replace the IF/ID contents with a NOP.
REQ-016 MultBusy  out  1  multi-cycle op occupies EX.

Function
REQ-017 FSM states SHALL be IDLE, BUSY and FLUSH, with a 4-bit down-counter Cnt.
REQ-018 Forwarding for A and B SHALL be combinational.
- EX/MEM hazard: EXMEM_RegWrite, EXMEM_Rd!=0 and EXMEM_Rd==IDEX_Rs (or IDEX_Rt) -> 10.
- Otherwise MEM/WB hazard under the same conditions -> 01.
- Otherwise -> 00.
- EX/MEM SHALL win when both stages match.
REQ-019 A load-use hazard SHALL be detected when IDEX_MemRead=1, IDEX_Rt!=0 and IDEX_Rt equals IFID_Rs or IFID_Rt.
REQ-020 In IDLE, on load-use with BranchTaken=0 and IDEX_MultStart=0, the same cycle SHALL drive PCWrite=0, IFIDWrite=0 and Bubble=1, for exactly one cycle, with the state unchanged.
REQ-021 In IDLE, IDEX_MultStart=1 SHALL take priority over load-use.
- Next state BUSY, Cnt<=MULT_CYCLES-1.
- Same cycle: ExHold=1, PCWrite=0, IFIDWrite=0, MultBusy=1.
REQ-022 In BUSY, the block SHALL drive ExHold=1, PCWrite=0, IFIDWrite=0, MultBusy=1 and decrement Cnt each cycle.
- At Cnt==1 the next state SHALL be IDLE.
- The total stall SHALL be exactly MULT_CYCLES cycles, counting the start cycle.
REQ-023 In BUSY, BranchTaken, IDEX_MultStart and load-use SHALL be ignored.
REQ-024 In IDLE, BranchTaken=1 SHALL have highest priority after Rst.
- Same cycle: FlushIFID=1, Bubble=1, PCWrite=1, IFIDWrite=1.
- Next state FLUSH.
REQ-025 In FLUSH, the block SHALL drive FlushIFID=1 and Bubble=1 for one cycle, then return to IDLE; load-use, MultStart and BranchTaken SHALL be ignored.
- Total flush is two slots.
REQ-026 When no condition is active in IDLE, outputs SHALL be PCWrite=1, IFIDWrite=1, and Bubble, ExHold, FlushIFID, MultBusy=0.
REQ-027 Forwarding SHALL stay active in every state.
REQ-028 Cnt arithmetic SHALL be unsigned 4-bit and SHALL never wrap below 0.

Reset
REQ-029 Rst=1 at a posedge SHALL force state IDLE and Cnt=0, regardless of the current state, including mid-BUSY and mid-FLUSH.
REQ-030 While Rst=1, outputs SHALL be PCWrite=1, IFIDWrite=1, ForwardA=ForwardB=00, and Bubble, ExHold, FlushIFID, MultBusy=0.
REQ-031 The first cycle after Rst deasserts SHALL behave as IDLE.

Verification
REQ-032 Forwarding: EXMEM_RegWrite=1, EXMEM_Rd=5, MEMWB_RegWrite=1, MEMWB_Rd=5, IDEX_Rs=5, IDEX_Rt=0 -> ForwardA=10, ForwardB=00; repeat with EXMEM_Rd=0 -> ForwardA=01.
REQ-033 Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rt=8 for one cycle -> PCWrite=0, IFIDWrite=0, Bubble=1 for that cycle only; repeat with IDEX_Rt=0 -> no stall.
REQ-034 Multi-cycle: IDEX_MultStart=1 pulse with MULT_CYCLES=4 -> ExHold=MultBusy=1 for exactly 4 cycles, then IDLE; BranchTaken=1 in cycle 2 -> FlushIFID stays 0.
REQ-035 Branch: BranchTaken=1 with a load-use hazard present in the same IDLE cycle -> FlushIFID=1 for 2 cycles, PCWrite=1, no load-use stall.
REQ-036 Reset mid-op: Rst=1 during BUSY at Cnt=2 -> the next cycle is IDLE with MultBusy=0 and Cnt=0.
